// File: rtl/btn_events_pkg.sv
// Shared types and constants for the button event block.
package btn_events_pkg;

  typedef enum logic [1:0] {
    ST_ARM,
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } state_e;

  localparam int MS_W = 16;

  function automatic int max_ms(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_events_ms_tick.sv
// 1 ms prescaler: counts 0..CLK_FREQ_KHZ-1 and ticks on the wrap.
// A restart forces the count to 0, so the next tick lands CLK_FREQ_KHZ cycles later.
module ms_tick #(
  parameter int CLK_FREQ_KHZ = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int W = (CLK_FREQ_KHZ > 1) ? $clog2(CLK_FREQ_KHZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_FREQ_KHZ - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/btn_events.sv
// Debounced button level to press/release/long-press/auto-repeat pulses; 2-cycle latency.
// Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined; otherwise rpt is tied low.
module btn_events
  import btn_events_pkg::*;
#(
  parameter int CLK_FREQ_KHZ = 100_000,
  parameter int LONG_MS      = 1000,
  parameter int REPEAT_MS    = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic rpt,
  output logic held
);

  localparam logic [MS_W-1:0] LONG_C  = MS_W'(LONG_MS);
  localparam logic [MS_W-1:0] CNT_MAX = MS_W'(max_ms(LONG_MS, REPEAT_MS));
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [MS_W-1:0] RPT_C   = MS_W'(REPEAT_MS);
`endif

  logic            btn_q;
  state_e          state_q, state_d;
  logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
  logic [MS_W-1:0] ms_inc;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            long_q, long_d;
  logic            held_q, held_d;
  logic            restart;
  logic            tick;

  ms_tick #(
    .CLK_FREQ_KHZ(CLK_FREQ_KHZ)
  ) u_ms_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  assign ms_inc = ms_cnt_q + MS_W'(1);

`ifdef BTN_AUTOREPEAT_EN
  logic rpt_q, rpt_d;
  assign rpt = rpt_q;
`else
  assign rpt = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ms_cnt_d  = ms_cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    restart   = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    rpt_d     = 1'b0;
`endif
    case (state_q)
      ST_ARM: begin
        if (!btn_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (btn_q) begin
          press_d  = 1'b1;
          restart  = 1'b1;
          ms_cnt_d = '0;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Release wins over a threshold crossing in the same cycle.
        if (!btn_q) begin
          release_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (tick && (ms_cnt_q != LONG_C) && (ms_cnt_q < CNT_MAX)) begin
          ms_cnt_d = ms_inc;
          if (ms_inc == LONG_C) begin
            long_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            ms_cnt_d = '0;
            state_d  = ST_REPEAT;
`endif
          end
        end
      end
`ifdef BTN_AUTOREPEAT_EN
      ST_REPEAT: begin
        if (!btn_q) begin
          release_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (tick) begin
          ms_cnt_d = ms_inc;
          if (ms_inc == RPT_C) begin
            rpt_d    = 1'b1;
            ms_cnt_d = '0;
          end
        end
      end
`endif
      default: begin
        state_d = ST_ARM;
      end
    endcase
    held_d = (state_d == ST_HOLD) || (state_d == ST_REPEAT);
  end

  // btn_q keeps sampling through reset so a button held across reset stays in ARM.
  always_ff @(posedge clk) begin
    btn_q <= btn;
    if (rst) begin
      state_q   <= ST_ARM;
      ms_cnt_q  <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rpt_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ms_cnt_q  <= ms_cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      held_q    <= held_d;
`ifdef BTN_AUTOREPEAT_EN
      rpt_q     <= rpt_d;
`endif
    end
  end

  assign press         = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;
  assign held          = held_q;

endmodule

// File: doc/btn_events.md
# btn_events

Converts a debounced push-button level into one-cycle event pulses for the stopwatch control logic: press, release, long-press and auto-repeat. Sits directly after the per-button debouncer and feeds start/stop/lap/reset decoding. All timing derives from a 1 ms tick generated internally from the system clock.

## Interface
- CLK_FREQ_KHZ, 100_000: system clock frequency in kHz; also the number of cycles per 1 ms tick.
- LONG_MS, 1000: hold time in ms before `long_press`; legal range 1..65535.
- REPEAT_MS, 200: auto-repeat period in ms after `long_press`; legal range 1..65535.
- clk  input  1  system clock; everything is on the rising edge.
- rst  input  1  reset: synchronous and active-high.
- btn  input  1  debounced button level; 1 means pressed.
- press  output  1  one-cycle pulse on an accepted press.
- release  output  1  one-cycle pulse on release after an accepted press.
- long_press  output  1  one-cycle pulse once per hold, LONG_MS after `press`.
- rpt  output  1  one-cycle pulse every REPEAT_MS after `long_press` while held.
- held  output  1  level; high from the `press` pulse through the cycle before `release`.

## Operation
- Input stage: `btn` is registered once into `btn_q`. The FSM acts only on `btn_q`.
- FSM states:
  - ARM: after reset. Waits for `btn_q == 0`, then goes to IDLE. A button held through reset never produces `press`.
  - IDLE: `btn_q == 1` → pulse `press`, clear the ms counter, restart the prescaler, go to HOLD.
  - HOLD: on each 1 ms tick, increment the ms counter. When the counter reaches LONG_MS, pulse `long_press`, clear the counter and go to REPEAT.
  - REPEAT: on each tick, increment the counter. When the counter reaches REPEAT_MS, pulse `rpt` and clear the counter.
- Release: `btn_q == 0` in HOLD or REPEAT → pulse `release` and go to IDLE. This takes priority over a `long_press` or `rpt` that would fire in the same cycle; that pulse is suppressed.
- Prescaler: counts 0..CLK_FREQ_KHZ-1 and ticks on the wrap. It is restarted at the `press` cycle, so the first tick comes exactly CLK_FREQ_KHZ cycles later.
- The ms counter is 16 bits. It never exceeds max(LONG_MS, REPEAT_MS), so it cannot wrap.
- At most one of `press`, `release`, `long_press`, `rpt` is high in any cycle.

## Timing
- Reset: all outputs are 0, state is ARM, counters are 0. Reset asserted mid-hold drops `held` on the next edge and emits no `release`.
- Press latency: `btn` rising before edge N → `btn_q` is 1 after edge N → `press` and `held` are high after edge N+1. That is 2 cycles.
- Release latency: also 2 cycles. `held` falls in the same cycle that `release` is high.
- `long_press` is high exactly LONG_MS·CLK_FREQ_KHZ cycles after the `press` cycle.
- The first `rpt` is REPEAT_MS·CLK_FREQ_KHZ cycles after `long_press`; subsequent pulses follow at the same period.
- A one-cycle low glitch on `btn` is treated as a full release followed by a new press. Filtering glitches is the debouncer's job.

## Configuration
- `BTN_AUTOREPEAT_EN` defined: REPEAT state and the `rpt` output are generated as described above.
- `BTN_AUTOREPEAT_EN` undefined:
  - after `long_press` the FSM stays in HOLD with the counter frozen, until release;
  - `rpt` is tied to 0;
  - the REPEAT_MS parameter is accepted but ignored.

## Structure
- Package `btn_events_pkg`: state enum (ARM, IDLE, HOLD, REPEAT) and the 16-bit ms-count width constant.
- Sub-module `ms_tick`:
  - parameter CLK_FREQ_KHZ;
  - ports: clk, rst, restart in, tick out;
  - this is the prescaler, instantiated once.

## Test plan
All scenarios use CLK_FREQ_KHZ=4, LONG_MS=3, REPEAT_MS=2.
- Short press: `btn` high 5 cycles then low → `press` 2 cycles after the rise, `release` 2 cycles after the fall, no `long_press`, `held` high for 5 cycles.
- Long hold: `btn` high 40 cycles → `long_press` 12 cycles after `press`, then `rpt` at +8, +16 and +24 cycles, then `release`.
- Release colliding with threshold: `btn` falls so that `btn_q` drops on the `long_press` cycle → `release` only, no `long_press`.
- Reset while held: `btn` high, `rst` pulsed during HOLD → `held` is 0 after the reset edge, no `press` while `btn` stays high; after `btn` goes low then high, `press` fires normally.
- Macro off: 40-cycle hold → a single `long_press`, `rpt` stays 0 throughout, `release` fires normally.
- Glitch: `btn` low for 1 cycle during REPEAT → `release`, then `press` 1 cycle later, and the counters restart.
